// File: rtl/tug_game_ctrl.sv
// tug_game_ctrl: tug-of-war round/match sequencer; define CPU_PLAYER_EN to make a CPU drive the right player
module tug_game_ctrl #(
  parameter int NUM_LIGHTS  = 9,
  parameter int HOLD_CYCLES = 1024,
  parameter int MAX_SCORE   = 7,
  parameter int SCORE_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_l,
  input  logic                  key_r,
`ifdef CPU_PLAYER_EN
  input  logic [3:0]            cpu_level,
`endif
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [SCORE_W-1:0]    left_score,
  output logic [SCORE_W-1:0]    right_score,
  output logic [1:0]            winner,
  output logic                  match_over
);
  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [PW-1:0] CENTER = PW'((NUM_LIGHTS - 1) / 2);
  localparam logic [PW-1:0] LAST = PW'(NUM_LIGHTS - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] MAX_S = SCORE_W'(MAX_SCORE);
  localparam logic [NUM_LIGHTS-1:0] ONE = NUM_LIGHTS'(1);
  typedef enum logic [1:0] {PLAY, WIN_HOLD, MATCH_OVER} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SCORE_W-1:0] left_q, left_d, right_q, right_d;
  logic [1:0] winner_q, winner_d;
  logic key_l_q, press_l, press_r, move_l, move_r;
  assign press_l = key_l & ~key_l_q;
`ifdef CPU_PLAYER_EN
  logic [9:0] lfsr_q;
  logic [3:0] div_q;
  logic unused_key_r;
  assign unused_key_r = key_r;
  // x^10+x^7+1 LFSR for CPU randomness, plus a 16-cycle opportunity divider
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 10'h001;
      div_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      div_q  <= div_q + 4'd1;
    end
  end
  assign press_r = (div_q == 4'hf) && (lfsr_q[3:0] < cpu_level);
`else
  logic key_r_q;
  // right key history for rising-edge detection
  always_ff @(posedge clk) key_r_q <= reset ? 1'b0 : key_r;
  assign press_r = key_r & ~key_r_q;
`endif
  assign move_l = press_l & ~press_r;
  assign move_r = press_r & ~press_l;
  // left key history for rising-edge detection
  always_ff @(posedge clk) key_l_q <= reset ? 1'b0 : key_l;
  // game state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      pos_q    <= CENTER;
      hold_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      hold_q   <= hold_d;
      left_q   <= left_d;
      right_q  <= right_d;
      winner_q <= winner_d;
    end
  end
  // light movement, round wins, inter-round pause and match end
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    hold_d   = hold_q;
    left_d   = left_q;
    right_d  = right_q;
    winner_d = winner_q;
    case (state_q)
      PLAY: begin
        if (move_l && pos_q == LAST) begin
          left_d   = left_q < MAX_S ? left_q + 1'b1 : left_q;
          winner_d = 2'b10;
          hold_d   = HOLD_LOAD;
          state_d  = WIN_HOLD;
        end else if (move_l) begin
          pos_d = pos_q + 1'b1;
        end else if (move_r && pos_q == '0) begin
          right_d  = right_q < MAX_S ? right_q + 1'b1 : right_q;
          winner_d = 2'b01;
          hold_d   = HOLD_LOAD;
          state_d  = WIN_HOLD;
        end else if (move_r) begin
          pos_d = pos_q - 1'b1;
        end
      end
      WIN_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (winner_q[1] ? left_q == MAX_S : right_q == MAX_S) begin
          state_d = MATCH_OVER;
        end else begin
          state_d  = PLAY;
          pos_d    = CENTER;
          winner_d = 2'b00;
        end
      end
      MATCH_OVER: state_d = MATCH_OVER;
      default: begin
        state_d  = PLAY;
        pos_d    = CENTER;
        hold_d   = '0;
        left_d   = '0;
        right_d  = '0;
        winner_d = 2'b00;
      end
    endcase
  end
  assign lights = state_q == PLAY ? ONE << pos_q : state_q == MATCH_OVER ? '1 : '0;
  assign left_score = left_q;
  assign right_score = right_q;
  assign winner = winner_q;
  assign match_over = state_q == MATCH_OVER;
endmodule
